// File: rtl/alu16_sequencer.sv
// alu16_sequencer
//
// Runs a 16-bit operation as two passes through an external combinational
// 8-bit ALU: the low byte first, then the high byte, with the low-byte
// carry fed back in. Commands arrive over a valid/ready handshake. The
// result and the aggregated 16-bit flags leave over a second valid/ready
// handshake.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid / cmd_ready       command handshake
//   cmd_op[2:0]                 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XNOR, 5 NOT,
//                               6 SHL, 7 CMP (ADC when ALU16_SEQ_ADC_EN)
//   cmd_a, cmd_b[15:0]          operands
//   rsp_valid / rsp_ready       response handshake
//   rsp_result[15:0]            result
//   rsp_carry/zero/overflow/negative   16-bit flags
//   alu_a, alu_b[7:0], alu_carry_in, alu_ctrl[4:0]   ALU drive
//   alu_result[7:0], alu_flag_*                      ALU return
//
// Configuration
//   ALU16_SEQ_ADC_EN  when defined, opcode 7 becomes ADC. ADC is ADD with the
//                     low-byte carry-in taken from the carry of the previous
//                     operation.
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a command; ALU parked
// LO    | ALU works on the low byte lanes
// HI    | ALU works on the high byte lanes, low carry chained in
// RSP   | response held until the consumer takes it

module alu16_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        rsp_overflow,
    output logic        rsp_negative,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_carry_in,
    output logic [4:0]  alu_ctrl,
    input  logic [7:0]  alu_result,
    input  logic        alu_flag_carry,
    input  logic        alu_flag_zero,
    input  logic        alu_flag_overflow,
    input  logic        alu_flag_negative
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XNOR = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    // Opcode 7 is CMP or ADC depending on the build.
    localparam logic [2:0] OP_7    = 3'd7;

    localparam logic [4:0] CTRL_ADD  = 5'b00000;
    localparam logic [4:0] CTRL_AND  = 5'b10000;
    localparam logic [4:0] CTRL_OR   = 5'b10001;
    localparam logic [4:0] CTRL_XNOR = 5'b10010;
    localparam logic [4:0] CTRL_NOT  = 5'b10011;
    localparam logic [4:0] CTRL_PARK = 5'b11111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [7:0]  lo_result;
    logic        lo_carry;
    logic        lo_zero;

`ifdef ALU16_SEQ_ADC_EN
    logic        saved_carry;
`endif

    // Byte lane currently presented to the ALU.
    logic [7:0] a_lane;
    logic [7:0] b_lane;
    logic       in_lo;
    logic       busy;

    assign in_lo  = (state == LO);
    assign busy   = (state == LO) || (state == HI);
    assign a_lane = in_lo ? a_q[7:0] : a_q[15:8];
    assign b_lane = in_lo ? b_q[7:0] : b_q[15:8];

    // Opcode classes used when the high-byte flags are captured. Opcode 7
    // is arithmetic in both builds (CMP or ADC).
    logic op_keeps_carry;
    logic op_keeps_ovf;
    logic op_is_cmp;

    assign op_keeps_carry = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                            (op_q == OP_SHL) || (op_q == OP_7);
    assign op_keeps_ovf   = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                            (op_q == OP_7);

`ifdef ALU16_SEQ_ADC_EN
    assign op_is_cmp = 1'b0;
`else
    assign op_is_cmp = (op_q == OP_7);
`endif

    logic hi_carry;
    logic hi_ovf;

    assign hi_carry = op_keeps_carry & alu_flag_carry;
    assign hi_ovf   = op_keeps_ovf & alu_flag_overflow;

    // ALU drive: a pure decode of the state register and the latched command,
    // so nothing on cmd_* can reach alu_* within a cycle.
    always_comb begin
        alu_ctrl     = CTRL_PARK;
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_carry_in = 1'b0;
        if (busy) begin
            unique case (op_q)
                OP_ADD: begin
                    alu_ctrl     = CTRL_ADD;
                    alu_a        = a_lane;
                    alu_b        = b_lane;
                    alu_carry_in = in_lo ? 1'b0 : lo_carry;
                end
                OP_SUB: begin
                    // Two's-complement subtract: A + ~B + 1, carry set means no borrow.
                    alu_ctrl     = CTRL_ADD;
                    alu_a        = a_lane;
                    alu_b        = ~b_lane;
                    alu_carry_in = in_lo ? 1'b1 : lo_carry;
                end
                OP_AND: begin
                    alu_ctrl = CTRL_AND;
                    alu_a    = a_lane;
                    alu_b    = b_lane;
                end
                OP_OR: begin
                    alu_ctrl = CTRL_OR;
                    alu_a    = a_lane;
                    alu_b    = b_lane;
                end
                OP_XNOR: begin
                    alu_ctrl = CTRL_XNOR;
                    alu_a    = a_lane;
                    alu_b    = b_lane;
                end
                OP_NOT: begin
                    alu_ctrl = CTRL_NOT;
                    alu_a    = a_lane;
                    alu_b    = 8'h00;
                end
                OP_SHL: begin
                    // A + A is a left shift; bit 7 of the low byte rides the carry chain.
                    alu_ctrl     = CTRL_ADD;
                    alu_a        = a_lane;
                    alu_b        = a_lane;
                    alu_carry_in = in_lo ? 1'b0 : lo_carry;
                end
                OP_7: begin
`ifdef ALU16_SEQ_ADC_EN
                    alu_ctrl     = CTRL_ADD;
                    alu_a        = a_lane;
                    alu_b        = b_lane;
                    alu_carry_in = in_lo ? saved_carry : lo_carry;
`else
                    alu_ctrl     = CTRL_ADD;
                    alu_a        = a_lane;
                    alu_b        = ~b_lane;
                    alu_carry_in = in_lo ? 1'b1 : lo_carry;
`endif
                end
                default: begin
                    alu_ctrl = CTRL_PARK;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_result   <= 16'h0000;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_negative <= 1'b0;
            op_q         <= 3'd0;
            a_q          <= 16'h0000;
            b_q          <= 16'h0000;
            lo_result    <= 8'h00;
            lo_carry     <= 1'b0;
            lo_zero      <= 1'b0;
`ifdef ALU16_SEQ_ADC_EN
            saved_carry  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    // cmd_ready stays low for the first cycle out of reset and
                    // rises here; the accept below takes precedence.
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        a_q       <= cmd_a;
                        b_q       <= cmd_b;
                        cmd_ready <= 1'b0;
                        state     <= LO;
                    end
                end
                LO: begin
                    lo_result <= alu_result;
                    lo_carry  <= alu_flag_carry;
                    lo_zero   <= alu_flag_zero;
                    state     <= HI;
                end
                HI: begin
                    // The low byte is kept aside until here so that the previous
                    // response stays intact until this capture.
                    rsp_result   <= op_is_cmp ? a_q : {alu_result, lo_result};
                    rsp_carry    <= hi_carry;
                    rsp_zero     <= lo_zero & alu_flag_zero;
                    rsp_overflow <= hi_ovf;
                    rsp_negative <= alu_flag_negative;
                    rsp_valid    <= 1'b1;
`ifdef ALU16_SEQ_ADC_EN
                    saved_carry  <= hi_carry;
`endif
                    state        <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Testbench for alu16_sequencer. It contains a behavioural model of the
// team's 8-bit combinational ALU. The 16-bit results checked against the
// sequencer are hand-computed constants.
// Build with +define+ALU16_SEQ_ADC_EN to cover the ADC variant.

module tb_alu16_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        rsp_overflow;
    logic        rsp_negative;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_carry_in;
    logic [4:0]  alu_ctrl;
    logic [7:0]  alu_result;
    logic        alu_flag_carry;
    logic        alu_flag_zero;
    logic        alu_flag_overflow;
    logic        alu_flag_negative;

    int n_cmp = 0;
    int n_bad = 0;

    alu16_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_a             (cmd_a),
        .cmd_b             (cmd_b),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_result        (rsp_result),
        .rsp_carry         (rsp_carry),
        .rsp_zero          (rsp_zero),
        .rsp_overflow      (rsp_overflow),
        .rsp_negative      (rsp_negative),
        .alu_a             (alu_a),
        .alu_b             (alu_b),
        .alu_carry_in      (alu_carry_in),
        .alu_ctrl          (alu_ctrl),
        .alu_result        (alu_result),
        .alu_flag_carry    (alu_flag_carry),
        .alu_flag_zero     (alu_flag_zero),
        .alu_flag_overflow (alu_flag_overflow),
        .alu_flag_negative (alu_flag_negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit ALU model
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum           = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
        alu_result        = 8'h00;
        alu_flag_carry    = 1'b0;
        alu_flag_overflow = 1'b0;
        case (alu_ctrl)
            5'b00000: begin
                alu_result        = alu_sum[7:0];
                alu_flag_carry    = alu_sum[8];
                alu_flag_overflow = (alu_a[7] == alu_b[7]) && (alu_sum[7] != alu_a[7]);
            end
            5'b10000: alu_result = alu_a & alu_b;
            5'b10001: alu_result = alu_a | alu_b;
            5'b10010: alu_result = ~(alu_a ^ alu_b);
            5'b10011: alu_result = ~alu_a;
            default:  alu_result = 8'h00;
        endcase
        alu_flag_zero     = (alu_result == 8'h00);
        alu_flag_negative = alu_result[7];
    end

    // Drives one command and collects its response. Flags are packed {C,Z,V,N}.
    task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic [3:0] flg,
                           output logic timed_out);
        timed_out = 1'b0;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!cmd_ready) timed_out = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        if (!rsp_valid) timed_out = 1'b1;
        res = rsp_result;
        flg = {rsp_carry, rsp_zero, rsp_overflow, rsp_negative};
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid);
        end
        n_cmp++;
        if ({rsp_result, rsp_carry, rsp_zero, rsp_overflow, rsp_negative} !== 20'h0) begin
            n_bad++; $display("FAIL reset_rsp got=%h/%b%b%b%b want=0000/0000",
                              rsp_result, rsp_carry, rsp_zero, rsp_overflow, rsp_negative);
        end
        n_cmp++;
        if (alu_ctrl !== 5'b11111 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_carry_in !== 1'b0) begin
            n_bad++; $display("FAIL reset_alu_park got ctrl=%b a=%h b=%h cin=%b want 11111/00/00/0",
                              alu_ctrl, alu_a, alu_b, alu_carry_in);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_cmd_ready got=%b want=1", cmd_ready);
        end
    endtask

    // Cycle-by-cycle ALU drive and latency for ADD 0x00FF + 0x0001.
    task automatic test_alu_drive();
        cmd_op = 3'd0; cmd_a = 16'h00FF; cmd_b = 16'h0001; cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_cmp++;
        if (alu_ctrl !== 5'b00000 || alu_a !== 8'hFF || alu_b !== 8'h01 || alu_carry_in !== 1'b0) begin
            n_bad++; $display("FAIL drive_lo got ctrl=%b a=%h b=%h cin=%b want 00000/ff/01/0",
                              alu_ctrl, alu_a, alu_b, alu_carry_in);
        end
        n_cmp++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL drive_lo_hs got rdy=%b vld=%b want 0/0", cmd_ready, rsp_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (alu_ctrl !== 5'b00000 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_carry_in !== 1'b1) begin
            n_bad++; $display("FAIL drive_hi got ctrl=%b a=%h b=%h cin=%b want 00000/00/00/1",
                              alu_ctrl, alu_a, alu_b, alu_carry_in);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL drive_hi_valid got=%b want=0", rsp_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h0100) begin
            n_bad++; $display("FAIL drive_latency got vld=%b res=%h want 1/0100", rsp_valid, rsp_result);
        end
        n_cmp++;
        if (alu_ctrl !== 5'b11111) begin
            n_bad++; $display("FAIL drive_rsp_park got ctrl=%b want=11111", alu_ctrl);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;

    task automatic test_ops();
        vec_t vecs[11];
        logic [15:0] res;
        logic [3:0]  flg;
        logic        to;
        //            op    a        b        result   CZVN
        vecs = '{'{3'd0, 16'h00FF, 16'h0001, 16'h0100, 4'b0000},
                 '{3'd1, 16'h0100, 16'h0001, 16'h00FF, 4'b1000},
                 '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0001},
                 '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011},
                 '{3'd6, 16'h8080, 16'hFFFF, 16'h0100, 4'b1000},
                 '{3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000},
                 '{3'd3, 16'h1200, 16'h0034, 16'h1234, 4'b0000},
                 '{3'd4, 16'hFF00, 16'h0F0F, 16'h0FF0, 4'b0000},
                 '{3'd5, 16'h00FF, 16'h1234, 16'hFF00, 4'b0001},
                 '{3'd0, 16'h8000, 16'h8000, 16'h0000, 4'b1110},
                 '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b1010}};
        for (int i = 0; i < 11; i++) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, res, flg, to);
            n_cmp++;
            if (to) begin
                n_bad++; $display("FAIL ops[%0d]_timeout handshake did not complete", i);
            end
            n_cmp++;
            if (res !== vecs[i].res) begin
                n_bad++; $display("FAIL ops[%0d]_result op=%0d got=%h want=%h", i, vecs[i].op, res, vecs[i].res);
            end
            n_cmp++;
            if (flg !== vecs[i].flg) begin
                n_bad++; $display("FAIL ops[%0d]_flags op=%0d got CZVN=%b want=%b", i, vecs[i].op, flg, vecs[i].flg);
            end
        end
    endtask

`ifndef ALU16_SEQ_ADC_EN
    task automatic test_cmp();
        logic [15:0] res;
        logic [3:0]  flg;
        logic        to;
        run_cmd(3'd7, 16'h1234, 16'h1234, res, flg, to);
        n_cmp++;
        if (to || res !== 16'h1234 || flg !== 4'b1100) begin
            n_bad++; $display("FAIL cmp_equal got res=%h CZVN=%b to=%b want 1234/1100/0", res, flg, to);
        end
        run_cmd(3'd7, 16'h0001, 16'h0002, res, flg, to);
        n_cmp++;
        if (to || res !== 16'h0001 || flg !== 4'b0001) begin
            n_bad++; $display("FAIL cmp_less got res=%h CZVN=%b to=%b want 0001/0001/0", res, flg, to);
        end
    endtask
`endif

    // Response held off for 5 cycles while the next command waits on cmd_valid.
    task automatic test_back_to_back();
        logic seen;
        cmd_op = 3'd0; cmd_a = 16'h0001; cmd_b = 16'h0002; cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_a = 16'h0005; cmd_b = 16'h0005;
        seen = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        seen = rsp_valid;
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL b2b_first_rsp timeout waiting for rsp_valid");
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_result !== 16'h0003 || cmd_ready !== 1'b0 ||
                {rsp_carry, rsp_zero, rsp_overflow, rsp_negative} !== 4'b0000) begin
                n_bad++; $display("FAIL b2b_hold[%0d] got vld=%b res=%h rdy=%b want 1/0003/0",
                                  i, rsp_valid, rsp_result, cmd_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_result !== 16'h0003) begin
            n_bad++; $display("FAIL b2b_after_hs got vld=%b rdy=%b res=%h want 0/1/0003",
                              rsp_valid, cmd_ready, rsp_result);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_cmp++;
        if (cmd_ready !== 1'b0 || rsp_result !== 16'h0003) begin
            n_bad++; $display("FAIL b2b_second_accept got rdy=%b res=%h want 0/0003", cmd_ready, rsp_result);
        end
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h000A) begin
            n_bad++; $display("FAIL b2b_second_rsp got vld=%b res=%h want 1/000a", rsp_valid, rsp_result);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [15:0] res;
        logic [3:0]  flg;
        logic        to;
        logic        any_valid;
        cmd_op = 3'd0; cmd_a = 16'h0003; cmd_b = 16'h0004; cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        any_valid = rsp_valid;
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL midrst_cmd_ready got=%b want=1", cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            any_valid = any_valid | rsp_valid;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (any_valid !== 1'b0 || rsp_result !== 16'h0000) begin
            n_bad++; $display("FAIL midrst_dropped got vld_seen=%b res=%h want 0/0000", any_valid, rsp_result);
        end
        run_cmd(3'd0, 16'h0001, 16'h0001, res, flg, to);
        n_cmp++;
        if (to || res !== 16'h0002 || flg !== 4'b0000) begin
            n_bad++; $display("FAIL midrst_next got res=%h CZVN=%b to=%b want 0002/0000/0", res, flg, to);
        end
    endtask

`ifdef ALU16_SEQ_ADC_EN
    task automatic test_adc();
        logic [15:0] res;
        logic [3:0]  flg;
        logic        to;
        run_cmd(3'd0, 16'hFFFF, 16'h0001, res, flg, to);
        n_cmp++;
        if (to || res !== 16'h0000 || flg !== 4'b1100) begin
            n_bad++; $display("FAIL adc_setup got res=%h CZVN=%b to=%b want 0000/1100/0", res, flg, to);
        end
        run_cmd(3'd7, 16'h0000, 16'h0000, res, flg, to);
        n_cmp++;
        if (to || res !== 16'h0001 || flg !== 4'b0000) begin
            n_bad++; $display("FAIL adc_chained got res=%h CZVN=%b to=%b want 0001/0000/0", res, flg, to);
        end
        run_cmd(3'd0, 16'hFFFF, 16'h0001, res, flg, to);
        do_reset();
        run_cmd(3'd7, 16'h0000, 16'h0000, res, flg, to);
        n_cmp++;
        if (to || res !== 16'h0000 || flg !== 4'b0100) begin
            n_bad++; $display("FAIL adc_after_reset got res=%h CZVN=%b to=%b want 0000/0100/0", res, flg, to);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 16'h0000;
        cmd_b     = 16'h0000;
        rsp_ready = 1'b0;
        test_reset();
        test_alu_drive();
        test_ops();
`ifndef ALU16_SEQ_ADC_EN
        test_cmp();
`endif
        test_back_to_back();
        test_reset_midflight();
`ifdef ALU16_SEQ_ADC_EN
        test_adc();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
